// File: rtl/txn_mon_pkg.sv
// ---------------------------------------------------------------------------
// txn_mon_pkg : shared types and width helper for the transaction monitor
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package txn_mon_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ch_state_e;

  typedef enum logic [2:0] {
    OUT_NONE    = 3'd0,
    OUT_DONE    = 3'd1,
    OUT_ABORT   = 3'd2,
    OUT_TIMEOUT = 3'd3,
    OUT_PERR    = 3'd4
  } outcome_e;

  function automatic int lat_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/txn_mon_channel.sv
// ---------------------------------------------------------------------------
// txn_mon_channel : one window FSM with latency counter and outcome register
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module txn_mon_channel
  import txn_mon_pkg::*;
#(
  parameter  int MIN_LAT = 5,
  parameter  int MAX_LAT = 64,
  localparam int CNT_W   = lat_w(MAX_LAT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cancel,
  input  logic             accept,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             timeout,
  output logic             proto_err,
  output logic [CNT_W-1:0] latency,
  output logic             done_nxt
);

  ch_state_e        state;
  outcome_e         outcome;
  logic [CNT_W-1:0] cnt;

  // Lets the top count a done in the same edge that raises the done pulse.
  assign done_nxt = (state == WAIT) && !cancel && accept && (cnt >= CNT_W'(MIN_LAT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      outcome <= OUT_NONE;
      latency <= '0;
    end else begin
      outcome <= OUT_NONE;
      case (state)
        IDLE: begin
          if (start && cancel) begin
            outcome <= OUT_ABORT;
          end else if (start) begin
            state <= WAIT;
            cnt   <= CNT_W'(1);
          end else if (accept) begin
            outcome <= OUT_PERR;
          end
        end
        WAIT: begin
          if (cancel) begin
            state   <= IDLE;
            cnt     <= '0;
            outcome <= OUT_ABORT;
          end else if (accept) begin
            state <= IDLE;
            cnt   <= '0;
            if (cnt < CNT_W'(MIN_LAT)) begin
              outcome <= OUT_PERR;
            end else begin
              outcome <= OUT_DONE;
              latency <= cnt;
            end
          end else if (cnt == CNT_W'(MAX_LAT)) begin
            state   <= IDLE;
            cnt     <= '0;
            outcome <= OUT_TIMEOUT;
          end else if (start) begin
            // Overlapping start freezes the counter for this cycle.
            outcome <= OUT_PERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy      = (state == WAIT);
  assign done      = (outcome == OUT_DONE);
  assign aborted   = (outcome == OUT_ABORT);
  assign timeout   = (outcome == OUT_TIMEOUT);
  assign proto_err = (outcome == OUT_PERR);

  // An open window reaching accept without cancel implies cancel stayed low since start.
  cov_start_accept: cover property (@(posedge clk) disable iff (!rst_n)
    busy && accept && !cancel);

  ast_done_lat: assert property (@(posedge clk) disable iff (!rst_n)
    done |-> (latency >= CNT_W'(MIN_LAT)) && (latency <= CNT_W'(MAX_LAT)));

  ast_excl: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({done, aborted, timeout, proto_err}));

endmodule

`default_nettype wire

// File: rtl/txn_window_monitor.sv
// ---------------------------------------------------------------------------
// txn_window_monitor : multi-channel start/accept window tracker
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module txn_window_monitor
  import txn_mon_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int MIN_LAT = 5,
  parameter  int MAX_LAT = 64,
  localparam int CNT_W   = lat_w(MAX_LAT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       cancel,
  input  logic [NUM_CH-1:0]       accept,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       aborted,
  output logic [NUM_CH-1:0]       timeout,
  output logic [NUM_CH-1:0]       proto_err,
  output logic [NUM_CH*CNT_W-1:0] latency,
  output logic [15:0]             total_done
);

  localparam int POP_W = $clog2(NUM_CH + 1);

  logic [NUM_CH-1:0] done_nxt;
  logic [POP_W-1:0]  pop;
  logic [16:0]       sum;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    txn_mon_channel #(
      .MIN_LAT (MIN_LAT),
      .MAX_LAT (MAX_LAT)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[i]),
      .cancel    (cancel[i]),
      .accept    (accept[i]),
      .busy      (busy[i]),
      .done      (done[i]),
      .aborted   (aborted[i]),
      .timeout   (timeout[i]),
      .proto_err (proto_err[i]),
      .latency   (latency[i*CNT_W +: CNT_W]),
      .done_nxt  (done_nxt[i])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop = pop + POP_W'(done_nxt[i]);
    end
  end

  assign sum = {1'b0, total_done} + 17'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_done <= '0;
    end else if (sum[16]) begin
      total_done <= 16'hFFFF;
    end else begin
      total_done <= sum[15:0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_txn_window_monitor.sv
// ---------------------------------------------------------------------------
// tb_txn_window_monitor : directed stimulus with a queue-based scoreboard
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_txn_window_monitor;

  localparam int CNT_W  = 7;
  localparam int S_CW   = 3;
  localparam int K_DONE = 1;
  localparam int K_ABRT = 2;
  localparam int K_TOUT = 3;
  localparam int K_PERR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [3:0]        start, cancel, accept;
  logic [3:0]        busy, done, aborted, timeout, proto_err;
  logic [4*CNT_W-1:0] latency;
  logic [15:0]       total_done;

  logic [3:0]        s_start, s_cancel, s_accept;
  logic [3:0]        s_busy, s_done, s_aborted, s_timeout, s_proto_err;
  logic [4*S_CW-1:0] s_latency;
  logic [15:0]       s_total_done;

  txn_window_monitor #(.NUM_CH(4), .MIN_LAT(5), .MAX_LAT(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cancel(cancel), .accept(accept),
    .busy(busy), .done(done), .aborted(aborted), .timeout(timeout),
    .proto_err(proto_err), .latency(latency), .total_done(total_done)
  );

  txn_window_monitor #(.NUM_CH(4), .MIN_LAT(1), .MAX_LAT(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .cancel(s_cancel), .accept(s_accept),
    .busy(s_busy), .done(s_done), .aborted(s_aborted), .timeout(s_timeout),
    .proto_err(s_proto_err), .latency(s_latency), .total_done(s_total_done)
  );

  typedef struct {
    int cyc;
    int ch;
    int kind;
    int lat;
    int total;
  } ev_t;

  ev_t q[$];
  int  n_vec = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  exp_lat[4];
  int  exp_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle input pulse; on return cyc is the edge that sampled it.
  task automatic drive(input logic [3:0] s, input logic [3:0] c, input logic [3:0] a);
    start = s; cancel = c; accept = a;
    tick(1);
    start = '0; cancel = '0; accept = '0;
  endtask

  task automatic push(input int e, input int ch, input int kind);
    ev_t ev;
    ev.cyc = e; ev.ch = ch; ev.kind = kind; ev.lat = exp_lat[ch]; ev.total = exp_total;
    q.push_back(ev);
  endtask

  // Monitor: every pulse on any channel must match the head of the queue.
  always @(negedge clk) begin
    int nset, k, lat_act;
    ev_t ev;
    if (rst_n === 1'b1) begin
      for (int ch = 0; ch < 4; ch++) begin
        nset = int'(done[ch]) + int'(aborted[ch]) + int'(timeout[ch]) + int'(proto_err[ch]);
        if (nset != 0) begin
          k = done[ch] ? K_DONE : aborted[ch] ? K_ABRT : timeout[ch] ? K_TOUT : K_PERR;
          lat_act = int'(latency[ch*CNT_W +: CNT_W]);
          n_vec++;
          if (nset > 1) begin
            n_fail++;
            $display("FAIL excl ch%0d: %0d outcome pulses at cycle %0d, required 1", ch, nset, cyc);
          end else if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected ch%0d: kind %0d at cycle %0d, required no pulse", ch, k, cyc);
          end else begin
            ev = q.pop_front();
            if (ev.cyc != cyc || ev.ch != ch || ev.kind != k || ev.lat != lat_act ||
                ev.total != int'(total_done)) begin
              n_fail++;
              $display("FAIL event: got ch%0d kind %0d cyc %0d lat %0d total %0d, required ch%0d kind %0d cyc %0d lat %0d total %0d",
                       ch, k, cyc, lat_act, total_done, ev.ch, ev.kind, ev.cyc, ev.lat, ev.total);
            end
          end
        end
      end
    end
  end

  initial begin
    int e;
    rst_n = 1'b0;
    start = '0; cancel = '0; accept = '0;
    s_start = '0; s_cancel = '0; s_accept = '0;
    for (int i = 0; i < 4; i++) exp_lat[i] = 0;
    tick(2);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pulses", int'({done, aborted, timeout, proto_err}), 0);
    chk("reset_latency", int'(latency), 0);
    chk("reset_total", int'(total_done), 0);
    rst_n = 1'b1;
    tick(2);

    // ch0 legal accept at distance 5
    drive(4'h1, 4'h0, 4'h0); e = cyc;
    chk("ch0_busy_open", int'(busy[0]), 1);
    tick(4);
    drive(4'h0, 4'h0, 4'h1);
    exp_lat[0] = 5; exp_total = 1; push(e + 5, 0, K_DONE);
    tick(2);

    // ch1 early accept at distance 3
    drive(4'h2, 4'h0, 4'h0); e = cyc;
    tick(2);
    drive(4'h0, 4'h0, 4'h2);
    push(e + 3, 1, K_PERR);
    chk("ch1_busy_after_early", int'(busy[1]), 0);
    tick(2);

    // ch2 cancel+accept together, then start+cancel in idle
    drive(4'h4, 4'h0, 4'h0); e = cyc;
    tick(6);
    drive(4'h0, 4'h4, 4'h4);
    push(e + 7, 2, K_ABRT);
    drive(4'h4, 4'h4, 4'h0);
    push(cyc, 2, K_ABRT);
    chk("ch2_busy_start_cancel", int'(busy[2]), 0);
    tick(2);

    // ch3 stray accept
    drive(4'h0, 4'h0, 4'h8);
    push(cyc, 3, K_PERR);
    tick(2);

    // ch0 overlap start holds the counter for one cycle
    drive(4'h1, 4'h0, 4'h0); e = cyc;
    tick(1);
    drive(4'h1, 4'h0, 4'h0);
    push(e + 2, 0, K_PERR);
    tick(4);
    drive(4'h0, 4'h0, 4'h1);
    exp_lat[0] = 6; exp_total = 2; push(e + 7, 0, K_DONE);
    tick(2);

    // ch3 timeout, then accept at exactly MAX_LAT
    drive(4'h8, 4'h0, 4'h0); e = cyc;
    push(e + 64, 3, K_TOUT);
    tick(63);
    chk("ch3_busy_before_timeout", int'(busy[3]), 1);
    tick(1);
    chk("ch3_busy_after_timeout", int'(busy[3]), 0);
    tick(2);
    drive(4'h8, 4'h0, 4'h0); e = cyc;
    tick(63);
    drive(4'h0, 4'h0, 4'h8);
    exp_lat[3] = 64; exp_total = 3; push(e + 64, 3, K_DONE);
    tick(2);

    // ch1 back-to-back windows
    drive(4'h2, 4'h0, 4'h0); e = cyc;
    tick(4);
    drive(4'h0, 4'h0, 4'h2);
    exp_lat[1] = 5; exp_total = 4; push(e + 5, 1, K_DONE);
    drive(4'h2, 4'h0, 4'h0);
    chk("ch1_busy_back_to_back", int'(busy[1]), 1);
    tick(5);
    drive(4'h0, 4'h0, 4'h2);
    exp_lat[1] = 6; exp_total = 5; push(e + 12, 1, K_DONE);
    tick(2);

    // all channels complete on the same edge
    drive(4'hF, 4'h0, 4'h0); e = cyc;
    tick(6);
    drive(4'h0, 4'h0, 4'hF);
    exp_total = 9;
    for (int ch = 0; ch < 4; ch++) begin
      exp_lat[ch] = 7;
      push(e + 7, ch, K_DONE);
    end
    tick(2);
    chk("total_after_all4", int'(total_done), 9);

    // reset in the middle of an open window
    drive(4'h1, 4'h0, 4'h0);
    tick(2);
    #4;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_latency", int'(latency), 0);
    chk("midrst_total", int'(total_done), 0);
    exp_total = 0;
    for (int ch = 0; ch < 4; ch++) exp_lat[ch] = 0;
    tick(2);
    rst_n = 1'b1;
    tick(70);
    chk("postrst_busy", int'(busy), 0);
    drive(4'h1, 4'h0, 4'h0); e = cyc;
    tick(4);
    drive(4'h0, 4'h0, 4'h1);
    exp_lat[0] = 5; exp_total = 1; push(e + 5, 0, K_DONE);
    tick(3);
    chk("queue_drained", q.size(), 0);

    // saturation on the short-latency instance
    for (int r = 0; r < 16383; r++) begin
      s_start = 4'hF; tick(1); s_start = 4'h0;
      s_accept = 4'hF; tick(1); s_accept = 4'h0;
    end
    s_start = 4'h1; tick(1); s_start = 4'h0;
    s_accept = 4'h1; tick(1); s_accept = 4'h0;
    chk("sat_preload", int'(s_total_done), 32'hFFFD);
    s_start = 4'hF; tick(1); s_start = 4'h0;
    s_accept = 4'hF; tick(1); s_accept = 4'h0;
    chk("sat_done_pulses", int'(s_done), 32'hF);
    chk("sat_total", int'(s_total_done), 32'hFFFF);
    s_start = 4'hF; tick(1); s_start = 4'h0;
    s_accept = 4'hF; tick(1); s_accept = 4'h0;
    chk("sat_hold", int'(s_total_done), 32'hFFFF);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
